hit_scorer: RTL and testbench
=============================

// Module: hit_scorer
// PURPOSE
//  Frame-based bullet/alien collision detector and score keeper for the shooter game.
//  Sits beside bullet and alien in top: consumes their active flags and drives a hit pulse.
//  The hit pulse clears the bullet and respawns the alien; alien_hidden masks the alien pixels.
//  Keeps a 4-digit BCD score that survives round restarts (game_over) and clears only on rst.
// PARAMETERS
//  COOLDOWN_FRAMES  30  frames the alien stays hidden after a hit (1..255)
//  POINTS_PER_HIT   1   BCD points added per hit (1..9)
// PORTS
//  pixel_clk      in   1   pixel clock; the only clock
//  rst            in   1   synchronous, active-high; clears everything including score
//  round_rst      in   1   sync active-high (driven by game_over); clears detection state, keeps score
//  fsync          in   1   one-cycle pulse at frame start
//  active         in   1   visible video region
//  active_bullet  in   1   bullet pixel coverage at current hpos/vpos
//  active_alien   in   1   alien pixel coverage at current hpos/vpos
//  hit            out  1   one-cycle pulse: collision detected in the frame just ended
//  alien_hidden   out  1   high while in COOLDOWN; top gates pixel_alien/active_alien with it
//  score_bcd      out  16  score, 4 BCD digits, [15:12] = thousands
//  score_max      out  1   high when score_bcd == 16'h9999
// BEHAVIOUR
//  Reset (rst or round_rst) values, taking effect on the next edge:
//   - hit=0, alien_hidden=0, state=ARMED, overlap=0, cooldown=0.
//   - rst also sets score_bcd=0 and score_max=0; round_rst leaves the score untouched.
//   - rst has priority over round_rst; both have priority over every event below.
//  Coincidence: coin = active & active_bullet & active_alien, evaluated every cycle.
//  overlap latch:
//   - In ARMED: set on any coin cycle; cleared on every fsync cycle.
//   - In COOLDOWN: never set.
//   - A coin on the fsync cycle itself counts toward the frame that is ending.
//  FSM, 2 states, transitions only on fsync cycles:
//   - ARMED, fsync & (overlap|coin): go COOLDOWN, cooldown <= COOLDOWN_FRAMES-1, hit <= 1, score += POINTS_PER_HIT.
//   - ARMED, fsync & no overlap: stay ARMED.
//   - COOLDOWN, fsync & cooldown==0: go ARMED. Otherwise cooldown <= cooldown-1.
//   - Net effect: alien_hidden stays high for exactly COOLDOWN_FRAMES whole frames.
//  Outputs are all registered:
//   - hit is high for exactly the one cycle after the triggering fsync; otherwise 0.
//   - alien_hidden = (state==COOLDOWN) and rises in the same cycle as hit.
//   - score_bcd updates on the same edge as hit rises.
//  Latency: collision pixel -> hit high is 1 cycle after the next fsync.
//  Multiple coincidences in one frame produce one hit only; no hit is possible while in COOLDOWN.
//  BCD add:
//   - Per-digit add with decimal carry (digit>9 -> digit-10, carry 1).
//   - Saturates at 9999: if the true sum exceeds 9999, the score becomes 9999.
//   - hit still pulses when the score is saturated.
//  score_max is registered from the next score value (score_next == 9999).
//  round_rst mid-COOLDOWN: returns to ARMED with alien_hidden=0 on the next edge; any pending overlap is discarded.
//  fsync while active=1 is legal; coin still requires active.
// TESTING
//  1. rst for 2 cycles; bullet/alien overlap 4 pixels in frame 0 -> hit=1 exactly one cycle after fsync 1; score 0000->0001; alien_hidden=1.
//  2. COOLDOWN_FRAMES=3, hit at fsync N -> alien_hidden high until the cycle after fsync N+3, low after; overlaps during frames N..N+2 -> no hit, score unchanged.
//  3. Preload score 0x0999 (via 999 hits, or force), one hit -> score_bcd=16'h1000; then hits up to 0x9999 -> score_max=1; one more hit -> hit pulses, score stays 9999.
//  4. POINTS_PER_HIT=7, score 0x0005 + hit -> 0x0012; score 0x9995 + hit -> 0x9999 saturated.
//  5. Coin only on the fsync cycle -> hit next cycle. Coin with active=0 -> no hit.
//  6. round_rst during COOLDOWN with score 0x0042 -> next cycle alien_hidden=0, state ARMED, score 0x0042. Then rst -> score 0x0000, score_max 0.

Source files
------------

// File: rtl/hit_scorer.sv
`default_nettype none
// ============================================================================
//  Module   : hit_scorer
//  Purpose  : Frame-based bullet/alien collision detector with a saturating
//             4-digit BCD score and post-hit alien cooldown.
//  Revision : 1.0 - initial release
// ============================================================================
module hit_scorer #(
    parameter int COOLDOWN_FRAMES = 30,
    parameter int POINTS_PER_HIT  = 1
) (
    input  logic        pixel_clk,
    input  logic        rst,
    input  logic        round_rst,
    input  logic        fsync,
    input  logic        active,
    input  logic        active_bullet,
    input  logic        active_alien,
    output logic        hit,
    output logic        alien_hidden,
    output logic [15:0] score_bcd,
    output logic        score_max
);

    localparam logic [0:0] c_ARMED         = 1'b0;
    localparam logic [0:0] c_COOLDOWN      = 1'b1;
    localparam logic [7:0] c_COOLDOWN_LOAD = 8'(COOLDOWN_FRAMES - 1);
    localparam logic [4:0] c_POINTS        = 5'(POINTS_PER_HIT);

    logic [0:0]  r_state;
    logic        r_overlap;
    logic [7:0]  r_cooldown;
    logic        r_hit;
    logic [15:0] r_score;
    logic        r_score_max;

    logic        w_coin;
    logic        w_trigger;
    logic        w_carry;
    logic [4:0]  w_digit;
    logic [15:0] w_score_sum;
    logic [15:0] w_score_next;

    assign w_coin    = active & active_bullet & active_alien;
    // A coincidence on the fsync cycle itself still belongs to the ending frame.
    assign w_trigger = fsync & (r_state == c_ARMED) & (r_overlap | w_coin);

    // Ripple decimal add; a carry out of the thousands digit means saturation.
    always_comb begin
        w_carry     = 1'b0;
        w_digit     = '0;
        w_score_sum = '0;
        for (int i = 0; i < 4; i++) begin
            w_digit = {1'b0, r_score[4*i +: 4]} + {4'd0, w_carry};
            if (i == 0) begin
                w_digit = w_digit + c_POINTS;
            end
            if (w_digit > 5'd9) begin
                w_digit = w_digit - 5'd10;
                w_carry = 1'b1;
            end else begin
                w_carry = 1'b0;
            end
            w_score_sum[4*i +: 4] = w_digit[3:0];
        end
        w_score_next = w_carry ? 16'h9999 : w_score_sum;
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_state     <= c_ARMED;
            r_overlap   <= 1'b0;
            r_cooldown  <= '0;
            r_hit       <= 1'b0;
            r_score     <= '0;
            r_score_max <= 1'b0;
        end else if (round_rst) begin
            r_state    <= c_ARMED;
            r_overlap  <= 1'b0;
            r_cooldown <= '0;
            r_hit      <= 1'b0;
        end else begin
            r_hit <= w_trigger;
            if (fsync) begin
                r_overlap <= 1'b0;
                case (r_state)
                    c_ARMED: begin
                        if (w_trigger) begin
                            r_state     <= c_COOLDOWN;
                            r_cooldown  <= c_COOLDOWN_LOAD;
                            r_score     <= w_score_next;
                            r_score_max <= (w_score_next == 16'h9999);
                        end
                    end
                    default: begin
                        if (r_cooldown == 8'd0) begin
                            r_state <= c_ARMED;
                        end else begin
                            r_cooldown <= r_cooldown - 8'd1;
                        end
                    end
                endcase
            end else if ((r_state == c_ARMED) && w_coin) begin
                r_overlap <= 1'b1;
            end
        end
    end

    assign hit          = r_hit;
    assign alien_hidden = (r_state == c_COOLDOWN);
    assign score_bcd    = r_score;
    assign score_max    = r_score_max;

endmodule
`default_nettype wire

// File: tb/tb_hit_scorer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hit_scorer
//  Purpose  : Self-checking bench for hit_scorer using a frame-level model;
//             three instances differ in cooldown length and points per hit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hit_scorer;

    logic        pixel_clk = 1'b0;
    logic        rst, round_rst, fsync, active, active_bullet, active_alien;
    logic [2:0]  hit, alien_hidden, score_max;
    logic [15:0] score_bcd [3];

    int checks = 0;
    int errors = 0;

    // Model state: score as a plain integer, remaining hidden frames as a count.
    int cd  [3] = '{3, 2, 1};
    int pts [3] = '{1, 7, 1};
    int m_score  [3];
    int m_hidden [3];
    bit m_coin   [3];
    bit m_hit    [3];

    always #5 pixel_clk = ~pixel_clk;

    hit_scorer #(.COOLDOWN_FRAMES(3), .POINTS_PER_HIT(1)) u_dut_a (
        .pixel_clk(pixel_clk), .rst(rst), .round_rst(round_rst), .fsync(fsync),
        .active(active), .active_bullet(active_bullet), .active_alien(active_alien),
        .hit(hit[0]), .alien_hidden(alien_hidden[0]), .score_bcd(score_bcd[0]),
        .score_max(score_max[0]));

    hit_scorer #(.COOLDOWN_FRAMES(2), .POINTS_PER_HIT(7)) u_dut_b (
        .pixel_clk(pixel_clk), .rst(rst), .round_rst(round_rst), .fsync(fsync),
        .active(active), .active_bullet(active_bullet), .active_alien(active_alien),
        .hit(hit[1]), .alien_hidden(alien_hidden[1]), .score_bcd(score_bcd[1]),
        .score_max(score_max[1]));

    hit_scorer #(.COOLDOWN_FRAMES(1), .POINTS_PER_HIT(1)) u_dut_c (
        .pixel_clk(pixel_clk), .rst(rst), .round_rst(round_rst), .fsync(fsync),
        .active(active), .active_bullet(active_bullet), .active_alien(active_alien),
        .hit(hit[2]), .alien_hidden(alien_hidden[2]), .score_bcd(score_bcd[2]),
        .score_max(score_max[2]));

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'(v / 1000);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    // Drive one cycle, advance the model across the edge, settle past it.
    task automatic tick(input bit r, input bit rr, input bit f, input bit a, input bit b, input bit c);
        bit coin_now;
        rst = r; round_rst = rr; fsync = f; active = a; active_bullet = b; active_alien = c;
        @(posedge pixel_clk);
        coin_now = a & b & c;
        for (int k = 0; k < 3; k++) begin
            if (r) begin
                m_score[k] = 0; m_hidden[k] = 0; m_coin[k] = 0; m_hit[k] = 0;
            end else if (rr) begin
                m_hidden[k] = 0; m_coin[k] = 0; m_hit[k] = 0;
            end else begin
                m_hit[k] = 0;
                if (f) begin
                    if (m_hidden[k] == 0 && (m_coin[k] || coin_now)) begin
                        m_hit[k]    = 1;
                        m_score[k]  = (m_score[k] + pts[k] > 9999) ? 9999 : m_score[k] + pts[k];
                        m_hidden[k] = cd[k];
                    end else if (m_hidden[k] > 0) begin
                        m_hidden[k] = m_hidden[k] - 1;
                    end
                    m_coin[k] = 0;
                end else if (m_hidden[k] == 0 && coin_now) begin
                    m_coin[k] = 1;
                end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        tick(1, 0, 0, 0, 0, 0);
        tick(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (hit[k] !== 1'b0 || alien_hidden[k] !== 1'b0 || score_bcd[k] !== 16'h0000 || score_max[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset[%0d]: hit=%b hidden=%b score=%h max=%b, expected 0 0 0000 0",
                         k, hit[k], alien_hidden[k], score_bcd[k], score_max[k]);
            end
        end
    endtask

    task automatic test_basic_hit();
        tick(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 1, 1, 1);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 1, 1, 0);
        checks++;
        if (hit !== 3'b000) begin
            errors++;
            $display("FAIL basic_prehit: hit=%b expected 000", hit);
        end
        tick(0, 0, 1, 0, 0, 0);
        checks++;
        if (hit !== 3'b111 || alien_hidden !== 3'b111 || score_bcd[0] !== 16'h0001 || score_bcd[1] !== 16'h0007) begin
            errors++;
            $display("FAIL basic_hit: hit=%b hidden=%b scoreA=%h scoreB=%h expected 111 111 0001 0007",
                     hit, alien_hidden, score_bcd[0], score_bcd[1]);
        end
        tick(0, 0, 0, 0, 0, 0);
        checks++;
        if (hit !== 3'b000) begin
            errors++;
            $display("FAIL basic_pulse_width: hit=%b expected 000", hit);
        end
    endtask

    task automatic test_cooldown();
        for (int fr = 0; fr < 3; fr++) begin
            for (int i = 0; i < 4; i++) begin
                tick(0, 0, 0, 1, 1, 1);
                checks++;
                if (hit[0] !== 1'b0 || alien_hidden[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL cooldown_frame%0d: hit=%b hidden=%b expected 0 1", fr, hit[0], alien_hidden[0]);
                end
            end
            tick(0, 0, 1, 1, 0, 0);
            checks++;
            if (hit[0] !== 1'b0 || alien_hidden[0] !== (fr < 2) || score_bcd[0] !== 16'h0001) begin
                errors++;
                $display("FAIL cooldown_fsync%0d: hit=%b hidden=%b score=%h expected 0 %b 0001",
                         fr, hit[0], alien_hidden[0], score_bcd[0], fr < 2);
            end
        end
        tick(0, 0, 0, 1, 1, 1);
        tick(0, 0, 1, 0, 0, 0);
        checks++;
        if (hit[0] !== 1'b1 || score_bcd[0] !== 16'h0002 || alien_hidden[0] !== 1'b1) begin
            errors++;
            $display("FAIL cooldown_rearm: hit=%b score=%h hidden=%b expected 1 0002 1",
                     hit[0], score_bcd[0], alien_hidden[0]);
        end
    endtask

    task automatic test_fsync_coin();
        tick(1, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 1, 1, 0);
        tick(0, 0, 1, 1, 1, 1);
        checks++;
        if (hit !== 3'b111) begin
            errors++;
            $display("FAIL fsync_coin: hit=%b expected 111", hit);
        end
        tick(1, 0, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 1, 1);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0, 1, 1);
        tick(0, 0, 1, 0, 1, 1);
        checks++;
        if (hit !== 3'b000 || alien_hidden !== 3'b000 || score_bcd[0] !== 16'h0000) begin
            errors++;
            $display("FAIL inactive_coin: hit=%b hidden=%b score=%h expected 000 000 0000",
                     hit, alien_hidden, score_bcd[0]);
        end
    endtask

    task automatic test_bcd_carry();
        int n = 0;
        tick(1, 0, 0, 0, 0, 0);
        while (m_score[2] < 999 && n < 3000) begin tick(0, 0, 1, 1, 1, 1); n++; end
        checks++;
        if (score_bcd[2] !== 16'h0999) begin
            errors++;
            $display("FAIL carry_0999: score=%h expected 0999", score_bcd[2]);
        end
        n = 0;
        do begin tick(0, 0, 1, 1, 1, 1); n++; end while (!m_hit[2] && n < 5);
        checks++;
        if (hit[2] !== 1'b1 || score_bcd[2] !== 16'h1000) begin
            errors++;
            $display("FAIL carry_1000: hit=%b score=%h expected 1 1000", hit[2], score_bcd[2]);
        end
        n = 0;
        while (m_score[2] < 9999 && n < 25000) begin tick(0, 0, 1, 1, 1, 1); n++; end
        checks++;
        if (score_bcd[2] !== 16'h9999 || score_max[2] !== 1'b1) begin
            errors++;
            $display("FAIL carry_9999: score=%h max=%b expected 9999 1", score_bcd[2], score_max[2]);
        end
        n = 0;
        do begin tick(0, 0, 1, 1, 1, 1); n++; end while (!m_hit[2] && n < 5);
        checks++;
        if (hit[2] !== 1'b1 || score_bcd[2] !== 16'h9999 || score_max[2] !== 1'b1) begin
            errors++;
            $display("FAIL carry_saturated: hit=%b score=%h max=%b expected 1 9999 1",
                     hit[2], score_bcd[2], score_max[2]);
        end
    endtask

    task automatic test_points();
        int n = 0;
        tick(1, 0, 0, 0, 0, 0);
        do begin tick(0, 0, 1, 1, 1, 1); n++; end while (!m_hit[1] && n < 5);
        do begin tick(0, 0, 1, 1, 1, 1); n++; end while (!m_hit[1] && n < 10);
        checks++;
        if (score_bcd[1] !== 16'h0014) begin
            errors++;
            $display("FAIL points_0014: score=%h expected 0014", score_bcd[1]);
        end
        n = 0;
        while (m_score[1] < 9996 && n < 6000) begin tick(0, 0, 1, 1, 1, 1); n++; end
        checks++;
        if (score_bcd[1] !== 16'h9996 || score_max[1] !== 1'b0) begin
            errors++;
            $display("FAIL points_9996: score=%h max=%b expected 9996 0", score_bcd[1], score_max[1]);
        end
        n = 0;
        do begin tick(0, 0, 1, 1, 1, 1); n++; end while (!m_hit[1] && n < 5);
        checks++;
        if (hit[1] !== 1'b1 || score_bcd[1] !== 16'h9999 || score_max[1] !== 1'b1) begin
            errors++;
            $display("FAIL points_saturate: hit=%b score=%h max=%b expected 1 9999 1",
                     hit[1], score_bcd[1], score_max[1]);
        end
    endtask

    task automatic test_round_rst();
        int n = 0;
        tick(1, 0, 0, 0, 0, 0);
        while (!(m_score[0] == 42 && m_hit[0]) && n < 400) begin tick(0, 0, 1, 1, 1, 1); n++; end
        checks++;
        if (alien_hidden[0] !== 1'b1 || score_bcd[0] !== 16'h0042) begin
            errors++;
            $display("FAIL round_setup: hidden=%b score=%h expected 1 0042", alien_hidden[0], score_bcd[0]);
        end
        tick(0, 1, 0, 0, 0, 0);
        checks++;
        if (alien_hidden !== 3'b000 || hit !== 3'b000 || score_bcd[0] !== 16'h0042) begin
            errors++;
            $display("FAIL round_rst: hidden=%b hit=%b score=%h expected 000 000 0042",
                     alien_hidden, hit, score_bcd[0]);
        end
        tick(0, 0, 0, 1, 1, 1);
        tick(0, 1, 0, 0, 0, 0);
        tick(0, 0, 1, 0, 0, 0);
        checks++;
        if (hit !== 3'b000) begin
            errors++;
            $display("FAIL round_overlap_discard: hit=%b expected 000", hit);
        end
        tick(0, 0, 1, 1, 1, 1);
        checks++;
        if (hit[0] !== 1'b1 || score_bcd[0] !== 16'h0043) begin
            errors++;
            $display("FAIL round_armed: hit=%b score=%h expected 1 0043", hit[0], score_bcd[0]);
        end
        tick(1, 0, 0, 0, 0, 0);
        checks++;
        if (score_bcd[0] !== 16'h0000 || score_max !== 3'b000 || alien_hidden !== 3'b000) begin
            errors++;
            $display("FAIL round_full_rst: score=%h max=%b hidden=%b expected 0000 000 000",
                     score_bcd[0], score_max, alien_hidden);
        end
    endtask

    task automatic test_random();
        tick(1, 0, 0, 0, 0, 0);
        for (int fr = 0; fr < 300; fr++) begin
            int len = $urandom_range(2, 10);
            for (int i = 0; i < len; i++) begin
                tick(0, ($urandom % 97) == 0, i == 0, ($urandom % 4) != 0, $urandom % 2, $urandom % 2);
                for (int k = 0; k < 3; k++) begin
                    checks++;
                    if (hit[k] !== m_hit[k] || alien_hidden[k] !== (m_hidden[k] > 0) ||
                        score_bcd[k] !== to_bcd(m_score[k]) || score_max[k] !== (m_score[k] == 9999)) begin
                        errors++;
                        $display("FAIL random[%0d] frame %0d: hit=%b hidden=%b score=%h max=%b expected %b %b %h %b",
                                 k, fr, hit[k], alien_hidden[k], score_bcd[k], score_max[k],
                                 m_hit[k], m_hidden[k] > 0, to_bcd(m_score[k]), m_score[k] == 9999);
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic_hit();
        test_cooldown();
        test_fsync_coin();
        test_round_rst();
        test_points();
        test_bcd_carry();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
